// File: rtl/ucsbece154_mem_pkg.sv
// rtl/ucsbece154_mem_pkg.sv - shared encodings and block geometry for the refill arbiter and caches
package ucsbece154_mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int BLOCK_WORDS_DEFAULT = 4;
    localparam int BLOCK_OFFSET_W      = $clog2(BLOCK_WORDS_DEFAULT) + 2;

    // Clears the byte offset within a block of 2**off_w bytes.
    function automatic logic [31:0] block_align(input logic [31:0] addr, input int unsigned off_w);
        return (addr >> off_w) << off_w;
    endfunction

endpackage

// File: rtl/ucsbece154_rr_pick.sv
// rtl/ucsbece154_rr_pick.sv - two-input owner picker; UCSBECE154_ARB_FIXED_PRIO_EN selects fixed D priority
import ucsbece154_mem_pkg::*;

module ucsbece154_rr_pick (
    input  logic   req_i,
    input  logic   req_d,
    input  owner_t last,
    output owner_t owner
);

`ifdef UCSBECE154_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;
    assign owner = req_d ? OWN_D : OWN_I;
`else
    // On a tie, serve the side that was not served last.
    always_comb begin
        owner = OWN_I;
        if (req_i && req_d) begin
            owner = (last == OWN_I) ? OWN_D : OWN_I;
        end else if (req_d) begin
            owner = OWN_D;
        end
    end
`endif

endmodule

// File: rtl/ucsbece154_mem_arbiter.sv
// rtl/ucsbece154_mem_arbiter.sv - I/D cache refill arbiter for the SDRAM read port (UCSBECE154_ARB_FIXED_PRIO_EN via picker)
import ucsbece154_mem_pkg::*;

module ucsbece154_mem_arbiter #(
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEFAULT,
    parameter int WORD_SIZE   = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 IReadRequest,
    input  logic [31:0]          IReadAddress,
    output logic [WORD_SIZE-1:0] IDataIn,
    output logic                 IDataReady,
    output logic                 IGrant,
    input  logic                 DReadRequest,
    input  logic [31:0]          DReadAddress,
    output logic [WORD_SIZE-1:0] DDataIn,
    output logic                 DDataReady,
    output logic                 DGrant,
    output logic [31:0]          MemReadAddress,
    output logic                 MemReadRequest,
    input  logic [WORD_SIZE-1:0] MemDataIn,
    input  logic                 MemDataReady
);

    localparam int          CNT_W     = $clog2(BLOCK_WORDS);
    localparam int unsigned OFF_W     = $clog2(BLOCK_WORDS) + 2;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BLOCK_WORDS - 1);

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    owner_t           last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic             req_q, req_d;
    logic             igrant_q, igrant_d;
    logic             dgrant_q, dgrant_d;
    owner_t           pick;

    ucsbece154_rr_pick u_pick (
        .req_i (IReadRequest),
        .req_d (DReadRequest),
        .last  (last_q),
        .owner (pick)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            owner_q  <= OWN_I;
            last_q   <= OWN_I;
            cnt_q    <= '0;
            addr_q   <= '0;
            req_q    <= 1'b0;
            igrant_q <= 1'b0;
            dgrant_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            igrant_q <= igrant_d;
            dgrant_q <= dgrant_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        req_d    = req_q;
        igrant_d = igrant_q;
        dgrant_d = dgrant_q;
        unique case (state_q)
            IDLE: begin
                if (IReadRequest || DReadRequest) begin
                    state_d  = BURST;
                    owner_d  = pick;
                    addr_d   = block_align((pick == OWN_D) ? DReadAddress : IReadAddress, OFF_W);
                    req_d    = 1'b1;
                    igrant_d = (pick == OWN_I);
                    dgrant_d = (pick == OWN_D);
                    cnt_d    = '0;
                end
            end
            BURST: begin
                if (MemDataReady) begin
                    if (cnt_q == LAST_BEAT) begin
                        // Returning to IDLE forces one idle cycle before the next grant.
                        state_d  = IDLE;
                        req_d    = 1'b0;
                        igrant_d = 1'b0;
                        dgrant_d = 1'b0;
                        last_d   = owner_q;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign MemReadAddress = addr_q;
    assign MemReadRequest = req_q;
    assign IGrant         = igrant_q;
    assign DGrant         = dgrant_q;
    assign IDataIn        = MemDataIn;
    assign DDataIn        = MemDataIn;
    assign IDataReady     = MemDataReady & igrant_q;
    assign DDataReady     = MemDataReady & dgrant_q;

endmodule

// File: tb/tb_ucsbece154_mem_arbiter.sv
// tb/tb_ucsbece154_mem_arbiter.sv - directed self-checking bench for ucsbece154_mem_arbiter
module tb_ucsbece154_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        IReadRequest, DReadRequest, MemDataReady;
    logic [31:0] IReadAddress, DReadAddress, MemReadAddress;
    logic [31:0] IDataIn, DDataIn, MemDataIn;
    logic        IDataReady, DDataReady, IGrant, DGrant, MemReadRequest;

    int checks   = 0;
    int failures = 0;

    ucsbece154_mem_arbiter #(.BLOCK_WORDS(4), .WORD_SIZE(32)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .IReadRequest   (IReadRequest),
        .IReadAddress   (IReadAddress),
        .IDataIn        (IDataIn),
        .IDataReady     (IDataReady),
        .IGrant         (IGrant),
        .DReadRequest   (DReadRequest),
        .DReadAddress   (DReadAddress),
        .DDataIn        (DDataIn),
        .DDataReady     (DDataReady),
        .DGrant         (DGrant),
        .MemReadAddress (MemReadAddress),
        .MemReadRequest (MemReadRequest),
        .MemDataIn      (MemDataIn),
        .MemDataReady   (MemDataReady)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic check_port(input string tag, input logic req, input logic ig, input logic dg,
                              input logic [31:0] addr);
        chk({tag, "_memreq"}, {31'd0, MemReadRequest}, {31'd0, req});
        chk({tag, "_igrant"}, {31'd0, IGrant}, {31'd0, ig});
        chk({tag, "_dgrant"}, {31'd0, DGrant}, {31'd0, dg});
        chk({tag, "_addr"}, MemReadAddress, addr);
    endtask

    // Drives four beats; owner_i selects which side must see the strobes.
    task automatic run_burst(input string tag, input logic owner_i, input logic [31:0] base);
        for (int k = 0; k < 4; k++) begin
            MemDataReady = 1'b1;
            MemDataIn    = base + 32'(k);
            #1;
            chk({tag, "_irdy"}, {31'd0, IDataReady}, {31'd0, owner_i});
            chk({tag, "_drdy"}, {31'd0, DDataReady}, {31'd0, ~owner_i});
            chk({tag, "_data"}, owner_i ? IDataIn : DDataIn, base + 32'(k));
            tick();
            MemDataReady = 1'b0;
            chk({tag, "_req_after_beat"}, {31'd0, MemReadRequest}, {31'd0, (k < 3)});
        end
    endtask

    initial begin
        Reset = 1'b1; IReadRequest = 1'b0; DReadRequest = 1'b0; MemDataReady = 1'b0;
        IReadAddress = '0; DReadAddress = '0; MemDataIn = '0;
        tick(); tick();
        check_port("reset", 1'b0, 1'b0, 1'b0, 32'h0);
        Reset = 1'b0;

        // Spurious beat while idle
        MemDataReady = 1'b1; MemDataIn = 32'hDEAD;
        #1;
        chk("spur_irdy", {31'd0, IDataReady}, 32'd0);
        chk("spur_drdy", {31'd0, DDataReady}, 32'd0);
        tick();
        MemDataReady = 1'b0;
        check_port("spur_after", 1'b0, 1'b0, 1'b0, 32'h0);

        // I-only request
        IReadRequest = 1'b1; IReadAddress = 32'h0000_1234;
        tick();
        check_port("ionly_grant", 1'b1, 1'b1, 1'b0, 32'h0000_1230);
        run_burst("ionly", 1'b1, 32'hA0);
        IReadRequest = 1'b0;
        check_port("ionly_end", 1'b0, 1'b0, 1'b0, 32'h0000_1230);

        // Reset so LAST=I, then tie: expect D, I, D
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        IReadRequest = 1'b1; DReadRequest = 1'b1;
        IReadAddress = 32'h100; DReadAddress = 32'h200;
        tick();
        check_port("rr1_grant", 1'b1, 1'b0, 1'b1, 32'h200);
        run_burst("rr1", 1'b0, 32'hB0);
        check_port("rr1_idle", 1'b0, 1'b0, 1'b0, 32'h200);
        tick();
        check_port("rr2_grant", 1'b1, 1'b1, 1'b0, 32'h100);
        run_burst("rr2", 1'b1, 32'hC0);
        check_port("rr2_idle", 1'b0, 1'b0, 1'b0, 32'h100);
        tick();
        check_port("rr3_grant", 1'b1, 1'b0, 1'b1, 32'h200);

        // Reset after two beats of the D burst
        for (int k = 0; k < 2; k++) begin
            MemDataReady = 1'b1; MemDataIn = 32'hE0 + 32'(k);
            tick();
        end
        MemDataReady = 1'b0;
        Reset = 1'b1; IReadRequest = 1'b0; DReadRequest = 1'b0;
        tick();
        check_port("midrst", 1'b0, 1'b0, 1'b0, 32'h0);
        Reset = 1'b0;

        // Fresh I burst; owner drops request after the first beat
        IReadRequest = 1'b1; IReadAddress = 32'h0000_3008;
        tick();
        check_port("drop_grant", 1'b1, 1'b1, 1'b0, 32'h0000_3000);
        MemDataReady = 1'b1; MemDataIn = 32'hF0;
        tick();
        MemDataReady = 1'b0;
        IReadRequest = 1'b0;
        check_port("drop_b1", 1'b1, 1'b1, 1'b0, 32'h0000_3000);
        for (int k = 1; k < 4; k++) begin
            MemDataReady = 1'b1; MemDataIn = 32'hF0 + 32'(k);
            #1;
            chk("drop_irdy", {31'd0, IDataReady}, 32'd1);
            tick();
            MemDataReady = 1'b0;
            chk("drop_req", {31'd0, MemReadRequest}, {31'd0, (k < 3)});
        end
        tick();
        check_port("drop_idle", 1'b0, 1'b0, 1'b0, 32'h0000_3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
